// File: rtl/instr_byte_fetch.sv
// In-order single-byte instruction fetcher: credit-limited memory reads into a byte FIFO, redirect flush/drain, wakeup pulse.
// Optional perf counters (perf_bytes, perf_stall) are present when FETCH_PERF_EN is defined.
module instr_byte_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_rvalid,
  output logic [7:0]  instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        wakeup
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_bytes,
  output logic [31:0] perf_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          wakeup_q;
  logic [7:0]    mem_q [DEPTH];

  logic [CW:0]   inflight;
  logic          credit, grant, resp, push, pop;

  // Buffered plus in-flight bytes are capped so the FIFO can never overflow.
  assign inflight    = {1'b0, count_q} + {1'b0, out_q};
  assign credit      = inflight < (CW+1)'(DEPTH);
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? mem_q[rd_q] : 8'h00;
  assign mem_addr    = pc_q;
  assign wakeup      = wakeup_q;

  always_comb begin
    mem_req = ~rst & (state_q == RUN) & credit & ~redirect;
    grant   = mem_req & mem_gnt;
    resp    = mem_rvalid & (out_q != '0);
    push    = resp & (state_q == RUN) & ~redirect;
    pop     = instr_valid & instr_ready;

    out_d   = out_q + CW'(grant) - CW'(resp);
    pc_d    = pc_q;
    count_d = count_q + CW'(push) - CW'(pop);
    wr_d    = wr_q + AW'(push);
    rd_d    = rd_q + AW'(pop);
    state_d = state_q;

    if (grant) pc_d = pc_q + 16'd1;

    if (redirect) begin
      pc_d    = redirect_pc;
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
    end

    // Stale responses must be swallowed before fetching from the new PC.
    if (redirect || state_q == DRAIN) begin
      state_d = (out_d != '0) ? DRAIN : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      out_q    <= '0;
      count_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      wakeup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      out_q    <= out_d;
      count_q  <= count_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      wakeup_q <= redirect;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= mem_rdata;
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bytes <= 32'd0;
      perf_stall <= 32'd0;
    end else begin
      if (pop) perf_bytes <= perf_bytes + 32'd1;
      if (!instr_valid && !redirect) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_byte_fetch.sv
// Scoreboard bench for instr_byte_fetch: memory model with configurable latency, expected bytes queued at grant.
module tb_instr_byte_fetch;

  localparam int          DEPTH = 4;
  localparam logic [15:0] RPC   = 16'h0000;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_gnt;
  logic [7:0]  mem_rdata;
  logic        mem_rvalid;
  logic [7:0]  instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        wakeup;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_bytes;
  logic [31:0] perf_stall;
`endif

  instr_byte_fetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_gnt     (mem_gnt),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .wakeup      (wakeup)
`ifdef FETCH_PERF_EN
    ,
    .perf_bytes  (perf_bytes),
    .perf_stall  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q [$];
  int          due_q [$];
  logic [7:0]  dat_q [$];
  logic [15:0] exp_pc;
  int          cyc, lat, grants, pops, wake_cnt;
  int          first_grant_cyc, first_valid_cyc;
  int          exp_bytes, exp_stall;
  bit          prev_redirect;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] mdata(input logic [15:0] a);
    return a[7:0] + a[15:8] + 8'h5A;
  endfunction

  task automatic do_reset();
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 8'h0;
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_wakeup", wakeup, 1'b0);
    check("rst_instr", instr, 8'h00);
    check("rst_mem_addr", mem_addr, RPC);
    exp_q.delete();
    due_q.delete();
    dat_q.delete();
    exp_pc = RPC;
    cyc = 0; grants = 0; pops = 0; wake_cnt = 0;
    first_grant_cyc = -1; first_valid_cyc = -1;
    exp_bytes = 0; exp_stall = 0;
    prev_redirect = 1'b0;
    rst = 1'b0;
  endtask

  // Called at a negedge: drive one cycle of inputs, score the cycle, advance to the next negedge.
  task automatic step(input bit red, input logic [15:0] rpc, input bit rdy, input bit gnt);
    redirect    = red;
    redirect_pc = rpc;
    instr_ready = rdy;
    mem_gnt     = gnt;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = dat_q.pop_front();
      void'(due_q.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 8'($urandom);
    end
    #1;
    check("wakeup", wakeup, prev_redirect);
    if (red) check("req_in_redirect", mem_req, 1'b0);
    if (mem_req && gnt) begin
      check("mem_addr", mem_addr, exp_pc);
      exp_q.push_back(mdata(exp_pc));
      due_q.push_back(cyc + lat);
      dat_q.push_back(mdata(mem_addr));
      check("credit_cap", exp_q.size() <= DEPTH, 1'b1);
      exp_pc = exp_pc + 16'd1;
      if (first_grant_cyc < 0) first_grant_cyc = cyc;
      grants++;
    end
    if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (instr_valid && rdy) begin
      if (exp_q.size() == 0) check("spurious_byte", instr_valid, 1'b0);
      else check("instr", instr, exp_q.pop_front());
      pops++;
      exp_bytes++;
    end
    if (!instr_valid && !red) exp_stall++;
    if (red) begin
      exp_q.delete();
      exp_pc = rpc;
    end
    if (wakeup) wake_cnt++;
    prev_redirect = red;
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout act=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    lat = 1;
    @(negedge clk);

    // Streaming with 1-cycle memory.
    do_reset();
    lat = 1;
    repeat (40) step(1'b0, 16'h0, 1'b1, 1'b1);
    check("first_latency", first_valid_cyc - first_grant_cyc, 2);
    check("stream_pops", pops, 38);

    // Frontend stalled: only DEPTH bytes fetched, then resume in order.
    do_reset();
    repeat (20) step(1'b0, 16'h0, 1'b0, 1'b1);
    check("stall_grants", grants, 4);
    check("stall_req", mem_req, 1'b0);
    check("stall_valid", instr_valid, 1'b1);
    repeat (20) step(1'b0, 16'h0, 1'b1, 1'b1);
    check("resume_fetch", grants > 4, 1'b1);

    // Push+pop at count=3 with one response arriving.
    do_reset();
    repeat (4) step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 16'h0, 1'b0, 1'b1);
    repeat (12) step(1'b0, 16'h0, 1'b1, 1'b1);

    // Redirect to 0xFFFE with three in flight.
    lat = 3;
    n = 0;
    while (due_q.size() != 3 && n < 50) begin
      step(1'b0, 16'h0, 1'b1, 1'b1);
      n++;
    end
    check("c_inflight", due_q.size(), 3);
    wake_cnt = 0;
    step(1'b1, 16'hFFFE, 1'b1, 1'b1);
    n = 0;
    while (due_q.size() > 0 && n < 10) begin
      step(1'b0, 16'h0, 1'b1, 1'b1);
      if (due_q.size() > 0) check("drain_no_req", mem_req, 1'b0);
      n++;
    end
    repeat (15) step(1'b0, 16'h0, 1'b1, 1'b1);
    check("c_wakeups", wake_cnt, 1);
    check("c_wrapped", grants > 0 && exp_pc > 16'h0002 && exp_pc < 16'h0100, 1'b1);

    // Random traffic with occasional redirects.
    for (int b = 0; b < 8; b++) begin
      lat = 1 + int'($urandom_range(0, 2));
      for (int i = 0; i < 50; i++) begin
        step($urandom_range(0, 39) == 0, 16'($urandom), $urandom_range(0, 2) != 0,
             $urandom_range(0, 3) != 0);
      end
    end
    lat = 1;
    repeat (15) step(1'b0, 16'h0, 1'b1, 1'b0);
    check("final_empty", exp_q.size(), 0);
    check("final_valid", instr_valid, 1'b0);
`ifdef FETCH_PERF_EN
    check("perf_bytes", perf_bytes, exp_bytes);
    check("perf_stall", perf_stall, exp_stall);
`endif

    // Reset in the middle of a drain.
    lat = 4;
    n = 0;
    while (due_q.size() < 3 && n < 50) begin
      step(1'b0, 16'h0, 1'b1, 1'b1);
      n++;
    end
    step(1'b1, 16'h1234, 1'b1, 1'b1);
    n = 0;
    while (due_q.size() > 2 && n < 10) begin
      step(1'b0, 16'h0, 1'b1, 1'b1);
      n++;
    end
    check("e_pending", due_q.size(), 2);
    do_reset();
    lat = 1;
    repeat (10) step(1'b0, 16'h0, 1'b1, 1'b1);
    check("restart_grants", grants > 0, 1'b1);
    check("restart_pops", pops > 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_byte_fetch.md
Name: instr_byte_fetch

Overview:
Instruction-byte supplier feeding the frontend's macro-op input. Keeps a 16-bit fetch PC and issues in-order single-byte reads to the instruction memory port. Buffers returned bytes in a small FIFO and presents them on an 8-bit valid/ready stream. Handles PC redirects by flushing buffered and in-flight bytes, and pulses wakeup to restart a terminated frontend.

Parameters:
DEPTH, 4, byte FIFO entries (power of 2, >=2); also the cap on bytes buffered plus in flight
RESET_PC, 16'h0000, fetch PC loaded at reset

Ports:
clk  input  1  clock
rst  input  1  reset
redirect  input  1  load new fetch PC this cycle
redirect_pc  input  16  new fetch PC
mem_addr  output  16  read address
mem_req  output  1  read request valid
mem_gnt  input  1  request accepted this cycle
mem_rdata  input  8  returned byte
mem_rvalid  input  1  response valid; in order, one per granted request
instr  output  8  byte to frontend
instr_valid  output  1  instr holds a valid byte
instr_ready  input  1  frontend accepts byte
wakeup  output  1  one-cycle restart pulse to frontend

Behaviour:
- Reset: single clock, synchronous, active-high rst. pc=RESET_PC; FIFO empty; outstanding=0; state=RUN. Outputs at reset: mem_req=0, instr_valid=0, wakeup=0, instr=0, mem_addr=RESET_PC. Reset mid-transfer discards everything, including responses in flight. After reset, RUN behaviour starts on the next cycle.
- Credit: count=FIFO occupancy, out=granted requests not yet answered. Credit is available when count+out < DEPTH.
- RUN: mem_req = credit available & ~redirect. mem_addr=pc. On mem_req&mem_gnt: pc<=pc+1, wrapping 16'hFFFF->16'h0000, and out++.
- Response: mem_rvalid in RUN pushes mem_rdata and decrements out. Credit rule guarantees the FIFO never overflows. mem_rvalid with out==0 is a protocol error: ignore it and hold out at 0.
- Output: instr/instr_valid come from the FIFO head, registered, with no combinational path from instr_ready. Pop on instr_valid&instr_ready. Push and pop in the same cycle leave count unchanged. Bytes are delivered strictly in address order.
- Bypass latency: a byte pushed in cycle N is visible with instr_valid=1 in cycle N+1. Minimum latency from grant to instr_valid is 1 + memory latency.
- Redirect, any state:
  - FIFO is flushed and instr_valid=0 next cycle. A pop in the redirect cycle still counts.
  - pc<=redirect_pc. No request is issued in the redirect cycle.
  - wakeup=1 in the cycle after redirect, for exactly one cycle.
  - If out (after that cycle's grant/response) is nonzero, go to DRAIN; otherwise stay in RUN.
- DRAIN: mem_req=0. Each mem_rvalid is discarded and decrements out. Leave for RUN in the cycle after out reaches 0. A redirect during DRAIN updates pc, pulses wakeup again, and stays in DRAIN.
- FIFO full with instr_ready=0: no new requests; state holds indefinitely.
- redirect and rst in the same cycle: rst wins.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds outputs perf_bytes[31:0] and perf_stall[31:0], both reset to 0 and wrapping at 2^32.
  - perf_bytes counts bytes popped to the frontend.
  - perf_stall counts cycles with instr_valid=0 and no redirect.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then 1-cycle memory with gnt=1 and instr_ready=1 -> bytes from 0x0000,0x0001,... appear one per cycle after the initial latency; mem_req never exceeds DEPTH=4 outstanding.
- instr_ready=0 for 20 cycles -> exactly 4 bytes accepted from memory, then mem_req=0. Release instr_ready -> bytes 0..3 in order, then fetching resumes at 0x0004.
- Redirect to 0xFFFE with 3 requests in flight -> DRAIN drops 3 responses; wakeup pulses once; next bytes come from 0xFFFE, 0xFFFF, 0x0000.
- Simultaneous pop and push with count=DEPTH-1, and with count=1 -> count unchanged, order preserved, no byte lost or duplicated.
- rst asserted mid-DRAIN with 2 responses still pending -> outputs return to reset values; fetch restarts at RESET_PC.
- With FETCH_PERF_EN defined: 10 pops and 5 empty cycles -> perf_bytes=10, perf_stall=5.
